// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;
endpackage

// File: rtl/arb_select.sv
// Combinational grant decision between fetch and data requesters.
// Tie-break alternates when ARB_ROUND_ROBIN_EN is defined, otherwise data wins.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   d_valid,
  input  owner_t last_grant,
  output owner_t winner
);
`ifdef ARB_ROUND_ROBIN_EN
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    winner = OWN_D;
    if (if_valid && d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
`else
      winner = OWN_D;
`endif
    end else if (if_valid) begin
      winner = OWN_IF;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data, one transaction
// at a time. Define ARB_ROUND_ROBIN_EN for alternating tie-break.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            winner, last_grant;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_rsp_valid_q, if_rsp_valid_d, d_rsp_valid_q, d_rsp_valid_d;
  logic              grant;

  // Ready is combinational, so it must also be gated while reset is held.
  assign grant = reset && (state_q == IDLE) && (if_req_valid || d_req_valid);

  arb_select u_arb_select (
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) last_grant_d = winner;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_grant_q <= OWN_D;
    else        last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_D;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    if_rsp_valid_d = 1'b0;
    d_rsp_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = REQ;
          owner_d = winner;
          if (winner == OWN_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d     = mem_rdata;
            if_rsp_valid_d = 1'b1;
          end else begin
            d_rdata_d      = mem_rdata;
            d_rsp_valid_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
    end
  end

  assign if_req_ready  = grant && (winner == OWN_IF);
  assign d_req_ready   = grant && (winner == OWN_D);
  assign if_rsp_valid  = if_rsp_valid_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign if_rdata      = if_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transactions,
// then hand-written spurious-response, reset-mid-WAIT and tie-break sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [63:0] if_rdata;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [7:0]  d_wstrb = '0;
  logic        d_rsp_valid;
  logic [63:0] d_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          stall;
    logic [63:0] rdata;
  } vec_t;

  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[5];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] exp_if_rdata = '0;
  logic [63:0] exp_d_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance one clock and act as the response monitor / scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (if_rsp_valid || d_rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: actual if_rsp_valid=%0b d_rsp_valid=%0b required none (cycle %0d)",
                 if_rsp_valid, d_rsp_valid, cyc);
      end else begin
        e = sb_q.pop_front();
        check("rsp_owner", 64'({if_rsp_valid, d_rsp_valid}), 64'(e.is_d ? 2'b01 : 2'b10));
        check("rsp_data", e.is_d ? d_rdata : if_rdata, e.data);
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int w;
    if_addr  = v.addr;
    d_addr   = v.addr;
    d_wdata  = v.wdata;
    d_we     = v.is_d ? v.we : 1'b1;
    d_wstrb  = v.is_d ? v.wstrb : 8'hFF;
    if_req_valid = !v.is_d;
    d_req_valid  = v.is_d;
    #1;
    w = 0;
    while (!(v.is_d ? d_req_ready : if_req_ready) && w < 8) begin
      tick();
      #1;
      w++;
    end
    if (w == 8) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: txn %0d actual no ready required ready within 8 cycles", idx);
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      return;
    end
    check("loser_ready", 64'(v.is_d ? if_req_ready : d_req_ready), 64'd0);
    sb_q.push_back('{is_d: v.is_d, data: v.rdata, cyc: cyc + 3 + v.stall});
    tick();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    check("mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("mem_addr", mem_addr, v.addr);
    check("mem_we", 64'(mem_we), 64'(v.is_d ? v.we : 1'b0));
    check("mem_wstrb", 64'(mem_wstrb), 64'(v.is_d ? v.wstrb : 8'h00));
    if (v.is_d && v.we) check("mem_wdata", mem_wdata, v.wdata);
    check("busy_req", 64'(busy), 64'd1);
    for (int i = 0; i < v.stall; i++) begin
      mem_req_ready = 1'b0;
      tick();
      check("stall_valid", 64'(mem_req_valid), 64'd1);
      check("stall_addr", mem_addr, v.addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wait_req_low", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = v.rdata;
    tick();
    mem_rsp_valid = 1'b0;
    if (v.is_d) exp_d_rdata = v.rdata;
    else        exp_if_rdata = v.rdata;
    check("other_rdata_hold", v.is_d ? if_rdata : d_rdata, v.is_d ? exp_if_rdata : exp_d_rdata);
    check("busy_idle", 64'(busy), 64'd0);
    $display("txn %0d: owner=%s addr=%h we=%0b rdata=%h", idx, v.is_d ? "D" : "IF", v.addr, v.we, v.rdata);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) tick();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_is_d[4];
    logic [63:0] tie_rdata;
    int          w;

    vecs[0] = '{1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 0, 64'h00000013_00A00093};
    vecs[1] = '{1'b1, 1'b1, 64'h2008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 1'b0, 64'h3000, 64'h0, 8'h00, 1, 64'h1111_2222_3333_4444};
    vecs[3] = '{1'b0, 1'b0, 64'h1004, 64'h0, 8'h00, 2, 64'hAAAA_5555_F0F0_0F0F};
    vecs[4] = '{1'b1, 1'b1, 64'h2010, 64'h5A5A_A5A5_0000_FFFF, 8'h0F, 0, 64'h7777_8888_9999_0000};

    // Reset state, with both requesters asserting so ready gating is exercised.
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    #1;
    check("rst_if_ready", 64'(if_req_ready), 64'd0);
    check("rst_d_ready", 64'(d_req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    check("rst_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    reset = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_txn(vecs[k], k);

    // Spurious response while idle must change nothing.
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFFFF_EEEE_DDDD_CCCC;
    tick();
    mem_rsp_valid = 1'b0;
    check("spur_busy", 64'(busy), 64'd0);
    check("spur_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("spur_if_rdata", if_rdata, exp_if_rdata);
    check("spur_d_rdata", d_rdata, exp_d_rdata);
    tick();
    $display("txn spurious: mem_rsp_valid in IDLE ignored");

    // Reset while WAIT: transaction abandoned, late response ignored.
    if_addr      = 64'h4000;
    if_req_valid = 1'b1;
    #1;
    check("mid_accept", 64'(if_req_ready), 64'd1);
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("mid_busy_wait", 64'(busy), 64'd1);
    apply_reset(1);
    check("mid_busy_after_rst", 64'(busy), 64'd0);
    check("mid_req_valid_after_rst", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    check("mid_busy_late_rsp", 64'(busy), 64'd0);
    check("mid_if_rdata", if_rdata, 64'd0);
    tick();
    $display("txn reset-mid-wait: abandoned fetch addr=0000000000004000");
    run_txn(vecs[0], 5);

    // Both requesters valid continuously for four transactions.
    apply_reset(1);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_is_d = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    if_addr = 64'h5000;
    d_addr  = 64'h6000;
    d_we    = 1'b0;
    d_wstrb = 8'h00;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tie_rdata = 64'hC0DE_0000_0000_0000 + 64'(k);
      #1;
      w = 0;
      while (!(if_req_ready || d_req_ready) && w < 8) begin
        tick();
        #1;
        w++;
      end
      check("tie_if_ready", 64'(if_req_ready), 64'(!exp_is_d[k]));
      check("tie_d_ready", 64'(d_req_ready), 64'(exp_is_d[k]));
      sb_q.push_back('{is_d: exp_is_d[k], data: tie_rdata, cyc: cyc + 3});
      tick();
      if (k == 3) begin
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
      end
      check("tie_mem_req_valid", 64'(mem_req_valid), 64'd1);
      check("tie_mem_addr", mem_addr, exp_is_d[k] ? 64'h6000 : 64'h5000);
      check("tie_mem_we", 64'(mem_we), 64'd0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = tie_rdata;
      tick();
      mem_rsp_valid = 1'b0;
      $display("txn tie %0d: owner=%s rdata=%h", k, exp_is_d[k] ? "D" : "IF", tie_rdata);
    end
    tick();
    tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
